arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
- Requester-side agent for the two-port round-robin arbiter (req/grant pair, single-cycle grants).
- Accepts a burst job (beat count) from local logic, raises a registered req, and counts one beat per cycle in which the arbiter grants.
- Drops req after the last beat and pulses done.
- Monitors consecutive ungranted req cycles and flags starvation. One instance sits on each arbiter port (A and B).

Parameters:
- LEN_W, 4, width of job length and beat counter (max burst 2^LEN_W-1).
- MAX_WAIT, 15, consecutive ungranted req cycles before starve asserts (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- job_valid  input  1  local logic offers a job.
- job_len  input  LEN_W  number of beats in offered job.
- job_ready  output  1  agent can accept a job (high only in IDLE).
- req  output  1  request to arbiter, driven directly from a flop.
- grant  input  1  grant from arbiter; may be combinational from req.
- beat  output  1  transfer beat this cycle (= req & grant, combinational).
- beats_left  output  LEN_W  beats remaining in current job (registered).
- done  output  1  one-cycle pulse after the job completes.
- starve  output  1  level; ungranted-wait counter has reached MAX_WAIT.

Behaviour:
- Reset, async, any state: state=IDLE, req=0, beats_left=0, done=0, wait_cnt=0, starve=0, job_ready=1. It takes effect immediately mid-burst. req falls without waiting for clk, and the partial job is discarded.
- States: IDLE, REQ. req=1 iff state==REQ; job_ready=1 iff state==IDLE.
- IDLE:
  - job_valid & job_len!=0: load beats_left=job_len, go to REQ. req rises the next cycle.
  - job_valid & job_len==0: accept, stay IDLE, pulse done the next cycle, req never asserts.
  - Else: hold.
- REQ, no grant: hold beats_left; wait_cnt increments, saturating at MAX_WAIT.
- REQ, grant:
  - beat=1, beats_left decrements, wait_cnt clears to 0.
  - If beats_left==1: go to IDLE, req=0 next cycle, done=1 next cycle (exactly one cycle).
- starve = (wait_cnt==MAX_WAIT), registered. Clears the cycle after a grant or on return to IDLE. It never blocks the request.
- Grant ignored while req=0: beat stays 0, no counter change.
- Job offers during REQ are not accepted (job_ready=0). The local side holds job_valid/job_len until accepted.
- A new job may be accepted in the same cycle done is high (state is already IDLE). Back-to-back jobs have exactly one req-low cycle between them, which lets the arbiter see a 0 and rebalance.
- No combinational path from grant to req. The beat path grant->beat is combinational only.
- Arithmetic:
  - beats_left is unsigned LEN_W and never underflows, because a decrement occurs only when beats_left>=1.
  - wait_cnt is width ceil(log2(MAX_WAIT+1)) and saturates.

Test Plan:
- Reset, then job_len=3 offered at cycle 0, grant tied 1 -> req high cycles 1-3, beat high cycles 1-3, beats_left 3,2,1,0, done high cycle 4 only, req low cycle 4.
- Two agents on the arbiter, both given job_len=4 together -> grants alternate A,B,A,B...; each agent's beats_left steps down every other cycle; both done after 8 beat cycles total; no cycle with both beats high.
- MAX_WAIT=15, job_len=2, grant held 0 for 20 cycles, then 1 -> starve rises after 15 ungranted req cycles, stays high through cycle 20, clears the cycle after first grant, job completes after 2 grants.
- job_len=0 offered -> job_ready stays 1, req stays 0, done pulses once the next cycle.
- job_len=5, grant=1; assert reset asynchronously mid-cycle after 2 beats -> req, beats_left, done, starve go to 0 before next clk edge; after release, job_ready=1 and no residual beats.
- Job B presented while job A in REQ -> job_ready=0, B not taken; B accepted in the done cycle of A, req low exactly one cycle between bursts.

Source files
------------

// File: rtl/arb_requester.sv
// Requester-side agent for a two-port round-robin arbiter: takes a burst job,
// holds a registered req until every beat is granted, pulses done, flags starvation.
module arb_requester #(
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             grant,
  output logic             beat,
  output logic [LEN_W-1:0] beats_left,
  output logic             done,
  output logic             starve
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
  endfunction

  // The only grant-dependent combinational output; req itself is a flop.
  assign beat     = req & grant;
  assign wait_nxt = sat_inc(wait_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req        <= 1'b0;
      job_ready  <= 1'b1;
      beats_left <= '0;
      done       <= 1'b0;
      wait_cnt   <= '0;
      starve     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          starve   <= 1'b0;
          if (job_valid) begin
            if (job_len != '0) begin
              state      <= REQ;
              req        <= 1'b1;
              job_ready  <= 1'b0;
              beats_left <= job_len;
            end else begin
              // Zero-length job: acknowledged with done, never reaches the arbiter.
              done <= 1'b1;
            end
          end
        end
        REQ: begin
          if (grant) begin
            beats_left <= beats_left - LEN_W'(1);
            wait_cnt   <= '0;
            starve     <= 1'b0;
            if (beats_left == LEN_W'(1)) begin
              state     <= IDLE;
              req       <= 1'b0;
              job_ready <= 1'b1;
              done      <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_nxt;
            starve   <= (wait_nxt == WAIT_MAX);
          end
        end
        default: begin
          state     <= IDLE;
          req       <= 1'b0;
          job_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: two agents behind a small round-robin arbiter model.
module tb_arb_requester;
  localparam int LEN_W    = 4;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset;
  logic jv_a, jv_b;
  logic [LEN_W-1:0] len_a, len_b;
  logic gnt_a, gnt_b;
  logic jr_a, req_a, beat_a, done_a, starve_a;
  logic jr_b, req_b, beat_b, done_b, starve_b;
  logic [LEN_W-1:0] bl_a, bl_b;
  logic arb_mode, force_ga, force_gb, last_b, end_flag;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    bit         agent;
    string      name;
    logic [8:0] val;
  } exp_t;
  exp_t q[$];
  logic [8:0] got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin arbiter model: last_b=1 means B was served last, so A has priority.
  assign gnt_a = arb_mode ? (req_a & (~req_b | last_b))  : force_ga;
  assign gnt_b = arb_mode ? (req_b & (~req_a | ~last_b)) : force_gb;
  always @(posedge clk) begin
    if (!arb_mode)   last_b <= 1'b1;
    else if (beat_a) last_b <= 1'b0;
    else if (beat_b) last_b <= 1'b1;
  end

  arb_requester #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) u_a (
    .clk(clk), .reset(reset), .job_valid(jv_a), .job_len(len_a), .job_ready(jr_a),
    .req(req_a), .grant(gnt_a), .beat(beat_a), .beats_left(bl_a), .done(done_a),
    .starve(starve_a));

  arb_requester #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) u_b (
    .clk(clk), .reset(reset), .job_valid(jv_b), .job_len(len_b), .job_ready(jr_b),
    .req(req_b), .grant(gnt_b), .beat(beat_b), .beats_left(bl_b), .done(done_b),
    .starve(starve_b));

  function automatic logic [8:0] pk(input logic jr, input logic rq, input logic bt,
                                    input logic [LEN_W-1:0] bl, input logic dn, input logic st);
    return {jr, rq, bt, bl, dn, st};
  endfunction

  task automatic exp_at(input int dc, input bit ag, input string nm, input logic [8:0] v);
    exp_t e;
    e.cyc = cyc + dc; e.agent = ag; e.name = nm; e.val = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: fields are {job_ready, req, beat, beats_left, done, starve}.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (end_flag || q[i].cyc <= cyc) begin
        got = q[i].agent ? {jr_b, req_b, beat_b, bl_b, done_b, starve_b}
                         : {jr_a, req_a, beat_a, bl_a, done_a, starve_a};
        checks++;
        if (q[i].cyc != cyc || got !== q[i].val) begin
          errors++;
          $display("FAIL %s agent=%0d cyc=%0d (at %0d) actual=%b required=%b",
                   q[i].name, q[i].agent, q[i].cyc, cyc, got, q[i].val);
        end
        q.delete(i);
      end
    end
    if (arb_mode) begin
      checks++;
      if (beat_a && beat_b) begin
        errors++;
        $display("FAIL both_beats cyc=%0d actual=11 required=not both", cyc);
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1; jv_a = 1'b0; jv_b = 1'b0; len_a = '0; len_b = '0;
    arb_mode = 1'b0; force_ga = 1'b0; force_gb = 1'b0; end_flag = 1'b0;
    repeat (3) step();

    // Reset state
    exp_at(0, 0, "rst_a", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_at(0, 1, "rst_b", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    step();
    reset = 1'b0;
    step();

    // Basic burst of 3, grant tied high (grant while idle must not beat)
    force_ga = 1'b1; jv_a = 1'b1; len_a = 4'd3;
    exp_at(0, 0, "b3_c0", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_at(1, 0, "b3_c1", pk(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0));
    exp_at(2, 0, "b3_c2", pk(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0));
    exp_at(3, 0, "b3_c3", pk(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0));
    exp_at(4, 0, "b3_c4", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    exp_at(5, 0, "b3_c5", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    step();
    jv_a = 1'b0;
    repeat (5) step();

    // Zero-length job
    force_ga = 1'b0; jv_a = 1'b1; len_a = 4'd0;
    exp_at(0, 0, "z_c0", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_at(1, 0, "z_c1", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    exp_at(2, 0, "z_c2", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    step();
    jv_a = 1'b0;
    repeat (2) step();

    // Starvation: 20 ungranted cycles, then grants
    jv_a = 1'b1; len_a = 4'd2;
    exp_at(1,  0, "sv_c1",  pk(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0));
    exp_at(15, 0, "sv_c15", pk(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0));
    exp_at(16, 0, "sv_c16", pk(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1));
    exp_at(20, 0, "sv_c20", pk(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1));
    exp_at(21, 0, "sv_c21", pk(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1));
    exp_at(22, 0, "sv_c22", pk(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0));
    exp_at(23, 0, "sv_c23", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    exp_at(24, 0, "sv_c24", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    step();
    jv_a = 1'b0;
    repeat (20) step();
    force_ga = 1'b1;
    repeat (4) step();

    // Async reset mid-burst after two beats
    jv_a = 1'b1; len_a = 4'd5;
    exp_at(1, 0, "ar_c1", pk(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0));
    exp_at(2, 0, "ar_c2", pk(1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0));
    exp_at(3, 0, "ar_mid", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_at(4, 0, "ar_c4", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_at(6, 0, "ar_c6", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    step();
    jv_a = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2) step();

    // Back-to-back: B offered during A, taken in A's done cycle
    jv_a = 1'b1; len_a = 4'd2;
    exp_at(0, 0, "bb_c0", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_at(1, 0, "bb_c1", pk(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0));
    exp_at(2, 0, "bb_c2", pk(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0));
    exp_at(3, 0, "bb_c3", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    exp_at(4, 0, "bb_c4", pk(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0));
    exp_at(5, 0, "bb_c5", pk(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0));
    exp_at(6, 0, "bb_c6", pk(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0));
    exp_at(7, 0, "bb_c7", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    exp_at(8, 0, "bb_c8", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    step();
    len_a = 4'd3;
    repeat (3) step();
    jv_a = 1'b0;
    repeat (4) step();
    force_ga = 1'b0;
    step();

    // Two agents sharing the round-robin arbiter, 4 beats each
    arb_mode = 1'b1;
    jv_a = 1'b1; len_a = 4'd4; jv_b = 1'b1; len_b = 4'd4;
    exp_at(0, 0, "rr_a0", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_at(0, 1, "rr_b0", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    for (int k = 1; k <= 7; k++)
      exp_at(k, 0, "rr_a", pk(1'b0, 1'b1, 1'(k % 2), LEN_W'(4 - k / 2), 1'b0, 1'b0));
    exp_at(8, 0, "rr_a_done", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    for (int k = 1; k <= 8; k++)
      exp_at(k, 1, "rr_b", pk(1'b0, 1'b1, 1'((k + 1) % 2), LEN_W'(4 - (k - 1) / 2), 1'b0, 1'b0));
    exp_at(9, 1, "rr_b_done", pk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    step();
    jv_a = 1'b0; jv_b = 1'b0;
    repeat (10) step();
    arb_mode = 1'b0;

    repeat (2) step();
    end_flag = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    c = q.size();
    if (c != 0) $display("FAIL leftover_expectations actual=%0d required=0", c);
    $display("CHECKS %0d ERRORS %0d", checks, errors + c);
    $finish;
  end
endmodule
